// File: rtl/rs_decoder.sv
// -----------------------------------------------------------------------------
// rs_decoder
//   Systematic RS(68,64) decoder over GF(2^8) (field poly 0x11D, alpha = 0x02,
//   generator roots alpha^0..alpha^3). One parallel codeword is latched, the
//   four syndromes are accumulated one symbol per clock (Horner), the result
//   is classified as no-error / single-error / uncorrectable, and the
//   (corrected) message is presented with a one-cycle strobe.
//
//   Codeword index k = 0..63 -> cw_msg_in[k], k = 64..67 -> cw_parity_in[k-64].
//   Symbol k carries polynomial degree 67-k.
//
// Ports
//   clk               clock
//   rst               asynchronous, active-high reset
//   cw_msg_in         received message symbols   [N_MSG][8]
//   cw_parity_in      received parity symbols    [N_PAR][8]
//   cw_valid          codeword present
//   cw_ready          decoder idle, accepts a codeword this cycle
//   msg_out           corrected (or raw) message [N_MSG][8]
//   msg_valid         one-cycle result strobe
//   err_corrected     single error found and fixed
//   err_uncorrectable syndromes inconsistent with 0 or 1 errors
//   err_pos           codeword index of the corrected symbol (0..67)
//
//   Latency: accept at edge E0, msg_valid high after E70, next accept at E71.
// -----------------------------------------------------------------------------
module rs_decoder #(
    parameter int N_MSG = 64,   // only 64 supported
    parameter int N_PAR = 4     // only 4 supported
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_MSG-1:0][7:0] cw_msg_in,
    input  logic [N_PAR-1:0][7:0] cw_parity_in,
    input  logic                  cw_valid,
    output logic                  cw_ready,
    output logic [N_MSG-1:0][7:0] msg_out,
    output logic                  msg_valid,
    output logic                  err_corrected,
    output logic                  err_uncorrectable,
    output logic [6:0]            err_pos
);

    localparam int N_SYM = N_MSG + N_PAR;   // 68

    typedef enum logic [1:0] {IDLE, SYND, EVAL, OUT} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_UNC} cls_t;
    typedef logic [255:0][7:0] tbl_t;

    // ---------------------------------------------------------------- GF(2^8)
    // Multiply by alpha: shift left, fold bit 7 back with 0x1D.
    function automatic logic [7:0] mul_a1(input logic [7:0] v);
        mul_a1 = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    endfunction

    // exp table: EXP_T[i] = alpha^i for i = 0..254 (entry 255 wraps to 1).
    function automatic tbl_t gen_exp();
        tbl_t       t;
        logic [7:0] v;
        t = '0;
        v = 8'h01;
        for (int i = 0; i < 256; i++) begin
            t[i] = v;
            v    = mul_a1(v);
        end
        gen_exp = t;
    endfunction

    // log table: LOG_T[alpha^i] = i. LOG_T[0] is a don't-care (callers gate zero).
    function automatic tbl_t gen_log();
        tbl_t       t;
        logic [7:0] v;
        t = '0;
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            t[v] = 8'(i);
            v    = mul_a1(v);
        end
        gen_log = t;
    endfunction

    localparam tbl_t EXP_T = gen_exp();
    localparam tbl_t LOG_T = gen_log();

    // General multiply: exponent sum mod 255, zero operand forces zero.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, LOG_T[a]} + {1'b0, LOG_T[b]};
        if (s >= 9'd255) s = s - 9'd255;
        if (a == 8'h00 || b == 8'h00) gf_mul = 8'h00;
        else                          gf_mul = EXP_T[s[7:0]];
    endfunction

    // ---------------------------------------------------------------- state
    state_t                 state_q;
    logic [N_MSG-1:0][7:0]  msg_q;
    logic [N_PAR-1:0][7:0]  par_q;
    logic [3:0][7:0]        s_q;        // S0..S3
    logic [6:0]             k_q;        // symbol counter during SYND
    cls_t                   cls_q;
    logic [6:0]             pos_q;

    logic [N_MSG-1:0][7:0]  msg_out_q;
    logic                   msg_valid_q;
    logic                   err_corrected_q;
    logic                   err_unc_q;
    logic [6:0]             err_pos_q;
    logic                   cw_ready_q;

    // ---------------------------------------------------------------- syndromes
    logic [7:0]      sym;
    logic [3:0][7:0] syn_d;

    always_comb begin
        sym = (k_q < 7'(N_MSG)) ? msg_q[k_q[5:0]] : par_q[k_q[1:0]];
        // S_j <= S_j * alpha^j ^ r_k : constant multiplies are chained xtimes.
        syn_d[0] = s_q[0] ^ sym;
        syn_d[1] = mul_a1(s_q[1]) ^ sym;
        syn_d[2] = mul_a1(mul_a1(s_q[2])) ^ sym;
        syn_d[3] = mul_a1(mul_a1(mul_a1(s_q[3]))) ^ sym;
    end

    // ---------------------------------------------------------------- classify
    logic       all_zero, all_nz, single_c;
    logic [7:0] s11, s02, s22, s13;
    logic [8:0] ldiff;
    logic [7:0] p_c;
    logic [6:0] pos_c;

    always_comb begin
        all_zero = (s_q == '0);
        all_nz   = (s_q[0] != 8'h00) && (s_q[1] != 8'h00) &&
                   (s_q[2] != 8'h00) && (s_q[3] != 8'h00);
        s11 = gf_mul(s_q[1], s_q[1]);
        s02 = gf_mul(s_q[0], s_q[2]);
        s22 = gf_mul(s_q[2], s_q[2]);
        s13 = gf_mul(s_q[1], s_q[3]);
        // For a single error e at degree d: S_j = e*alpha^(j*d), so S1/S0 = alpha^d.
        ldiff = {1'b0, LOG_T[s_q[1]]} + 9'd255 - {1'b0, LOG_T[s_q[0]]};
        p_c   = (ldiff >= 9'd255) ? 8'(ldiff - 9'd255) : ldiff[7:0];
        // Degrees above 67 lie outside the shortened code: not a single error.
        single_c = all_nz && (s11 == s02) && (s22 == s13) && (p_c <= 8'd67);
        pos_c    = 7'd67 - p_c[6:0];
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            msg_q           <= '0;
            par_q           <= '0;
            s_q             <= '0;
            k_q             <= '0;
            cls_q           <= CLS_NONE;
            pos_q           <= '0;
            msg_out_q       <= '0;
            msg_valid_q     <= 1'b0;
            err_corrected_q <= 1'b0;
            err_unc_q       <= 1'b0;
            err_pos_q       <= '0;
            cw_ready_q      <= 1'b1;
        end else begin
            msg_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cw_valid && cw_ready_q) begin
                        msg_q      <= cw_msg_in;
                        par_q      <= cw_parity_in;
                        s_q        <= '0;
                        k_q        <= '0;
                        cw_ready_q <= 1'b0;
                        state_q    <= SYND;
                    end
                end
                SYND: begin
                    s_q <= syn_d;
                    k_q <= k_q + 7'd1;
                    if (k_q == 7'(N_SYM - 1)) state_q <= EVAL;
                end
                EVAL: begin
                    pos_q <= '0;
                    if (all_zero) begin
                        cls_q <= CLS_NONE;
                    end else if (single_c) begin
                        cls_q <= CLS_SINGLE;
                        pos_q <= pos_c;
                    end else begin
                        cls_q <= CLS_UNC;
                    end
                    state_q <= OUT;
                end
                OUT: begin
                    // S0 is the error magnitude; parity positions never match
                    // a message index, so those pass the message unchanged.
                    for (int i = 0; i < N_MSG; i++) begin
                        msg_out_q[i] <= msg_q[i] ^
                            (((cls_q == CLS_SINGLE) && (pos_q == 7'(i))) ? s_q[0] : 8'h00);
                    end
                    msg_valid_q     <= 1'b1;
                    err_corrected_q <= (cls_q == CLS_SINGLE);
                    err_unc_q       <= (cls_q == CLS_UNC);
                    err_pos_q       <= (cls_q == CLS_SINGLE) ? pos_q : 7'd0;
                    cw_ready_q      <= 1'b1;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cw_ready          = cw_ready_q;
    assign msg_out           = msg_out_q;
    assign msg_valid         = msg_valid_q;
    assign err_corrected     = err_corrected_q;
    assign err_uncorrectable = err_unc_q;
    assign err_pos           = err_pos_q;

endmodule

// File: tb/tb_rs_decoder.sv
// -----------------------------------------------------------------------------
// tb_rs_decoder
//   Random codewords are built with a polynomial-division encoder model; the
//   expected decoder result follows from the injected error pattern alone
//   (weight 0 -> clean, weight 1 -> corrected at known index, weight 2/3 ->
//   uncorrectable, raw message).
// -----------------------------------------------------------------------------
module tb_rs_decoder;

    logic             clk, rst;
    logic [63:0][7:0] cw_msg_in;
    logic [3:0][7:0]  cw_parity_in;
    logic             cw_valid, cw_ready;
    logic [63:0][7:0] msg_out;
    logic             msg_valid, err_corrected, err_uncorrectable;
    logic [6:0]       err_pos;

    int errors, checks;
    logic [7:0] gp [0:4];   // generator polynomial, gp[d] = coeff of x^d

    // observations from the last decode
    int               obs_lat, obs_rdy_bad;
    logic             obs_rdy_start, obs_rdy_end, obs_vld2, obs_hold;
    logic [63:0][7:0] obs_mo;
    logic             obs_ec, obs_eu;
    logic [6:0]       obs_ep;

    rs_decoder #(.N_MSG(64), .N_PAR(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .cw_msg_in         (cw_msg_in),
        .cw_parity_in      (cw_parity_in),
        .cw_valid          (cw_valid),
        .cw_ready          (cw_ready),
        .msg_out           (msg_out),
        .msg_valid         (msg_valid),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .err_pos           (err_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bit-serial GF(2^8) multiply, poly 0x11D
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return r;
    endfunction

    task automatic build_gen();
        logic [7:0] root;
        root = 8'h01;
        gp[0] = 8'h01;
        for (int d = 1; d <= 4; d++) gp[d] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            for (int d = 4; d > 0; d--) gp[d] = gp[d-1] ^ gmul(root, gp[d]);
            gp[0] = gmul(root, gp[0]);
            root  = gmul(root, 8'h02);
        end
    endtask

    // remainder of m(x)*x^4 mod g(x); msg[0] is the highest degree
    function automatic logic [3:0][7:0] encode(input logic [63:0][7:0] m);
        logic [7:0]      rem [0:3];
        logic [7:0]      fb;
        logic [3:0][7:0] p;
        for (int i = 0; i < 4; i++) rem[i] = 8'h00;
        for (int k = 0; k < 64; k++) begin
            fb     = m[k] ^ rem[3];
            rem[3] = rem[2] ^ gmul(fb, gp[3]);
            rem[2] = rem[1] ^ gmul(fb, gp[2]);
            rem[1] = rem[0] ^ gmul(fb, gp[1]);
            rem[0] = gmul(fb, gp[0]);
        end
        for (int i = 0; i < 4; i++) p[i] = rem[3-i];
        return p;
    endfunction

    function automatic logic [63:0][7:0] rand_msg();
        logic [63:0][7:0] m;
        for (int k = 0; k < 64; k++) m[k] = 8'($urandom_range(0, 255));
        return m;
    endfunction

    // Drive one codeword and capture what the DUT reports (no checking here).
    task automatic decode(input logic [63:0][7:0] m, input logic [3:0][7:0] p);
        @(negedge clk);
        obs_rdy_start = cw_ready;
        cw_msg_in = m; cw_parity_in = p; cw_valid = 1'b1;
        @(posedge clk);                      // E0
        @(negedge clk);
        cw_valid = 1'b0;
        obs_lat = -1;
        obs_rdy_bad = cw_ready ? 1 : 0;
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (msg_valid) begin obs_lat = c; break; end
            if (cw_ready) obs_rdy_bad++;
        end
        obs_mo = msg_out; obs_ec = err_corrected; obs_eu = err_uncorrectable;
        obs_ep = err_pos; obs_rdy_end = cw_ready;
        @(posedge clk);
        @(negedge clk);
        obs_vld2 = msg_valid;
        obs_hold = (msg_out === obs_mo) && (err_corrected === obs_ec) &&
                   (err_uncorrectable === obs_eu) && (err_pos === obs_ep);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({cw_ready, msg_valid, err_corrected, err_uncorrectable} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/vld/ec/eu=%b want 1000",
                     {cw_ready, msg_valid, err_corrected, err_uncorrectable});
        end
        checks++;
        if (msg_out !== '0 || err_pos !== 7'd0) begin
            errors++;
            $display("FAIL reset_data: got msg_out=%h err_pos=%0d want 0", msg_out, err_pos);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        decode('0, '0);
        checks++;
        if (obs_lat !== 70) begin errors++; $display("FAIL zero_latency: got %0d want 70", obs_lat); end
        checks++;
        if (obs_rdy_start !== 1'b1 || obs_rdy_bad !== 0 || obs_rdy_end !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: start=%b busy_high_cycles=%0d end=%b want 1/0/1",
                     obs_rdy_start, obs_rdy_bad, obs_rdy_end);
        end
        checks++;
        if (obs_mo !== '0 || obs_ec !== 1'b0 || obs_eu !== 1'b0) begin
            errors++;
            $display("FAIL zero_result: msg=%h ec=%b eu=%b want 0/0/0", obs_mo, obs_ec, obs_eu);
        end
        checks++;
        if (obs_vld2 !== 1'b0 || obs_hold !== 1'b1) begin
            errors++;
            $display("FAIL zero_strobe: vld_next=%b hold=%b want 0/1", obs_vld2, obs_hold);
        end
    endtask

    task automatic test_clean_random();
        logic [63:0][7:0] m;
        for (int n = 0; n < 500; n++) begin
            m = rand_msg();
            decode(m, encode(m));
            checks++;
            if (obs_mo !== m || obs_ec !== 1'b0 || obs_eu !== 1'b0) begin
                errors++;
                $display("FAIL clean_%0d: msg=%h ec=%b eu=%b want msg=%h 0/0", n, obs_mo, obs_ec, obs_eu, m);
            end
            checks++;
            if (obs_lat !== 70) begin errors++; $display("FAIL clean_lat_%0d: got %0d want 70", n, obs_lat); end
        end
    endtask

    task automatic test_single();
        logic [63:0][7:0] m, r;
        logic [3:0][7:0]  p;
        logic [7:0]       e;
        r = '0;
        r[5] = 8'h37;
        decode(r, '0);
        checks++;
        if (obs_ec !== 1'b1 || obs_eu !== 1'b0 || obs_ep !== 7'd5 || obs_mo !== '0) begin
            errors++;
            $display("FAIL single_zero: ec=%b eu=%b pos=%0d msg=%h want 1/0/5/0", obs_ec, obs_eu, obs_ep, obs_mo);
        end
        for (int k = 0; k < 68; k++) begin
            m = rand_msg();
            p = encode(m);
            r = m;
            e = 8'($urandom_range(1, 255));
            if (k < 64) r[k] = r[k] ^ e;
            else        p[k-64] = p[k-64] ^ e;
            decode(r, p);
            checks++;
            if (obs_ec !== 1'b1 || obs_eu !== 1'b0 || obs_ep !== 7'(k) || obs_mo !== m) begin
                errors++;
                $display("FAIL single_k%0d: ec=%b eu=%b pos=%0d msg=%h want 1/0/%0d msg=%h",
                         k, obs_ec, obs_eu, obs_ep, obs_mo, k, m);
            end
        end
    endtask

    task automatic test_parity();
        logic [63:0][7:0] m;
        logic [3:0][7:0]  p;
        m = rand_msg();
        p = encode(m);
        p[3] = p[3] ^ 8'hA5;
        decode(m, p);
        checks++;
        if (obs_ec !== 1'b1 || obs_eu !== 1'b0 || obs_ep !== 7'd67 || obs_mo !== m) begin
            errors++;
            $display("FAIL parity3: ec=%b eu=%b pos=%0d msg=%h want 1/0/67 msg=%h", obs_ec, obs_eu, obs_ep, obs_mo, m);
        end
    endtask

    task automatic test_multi();
        logic [63:0][7:0] m, r;
        logic [3:0][7:0]  p;
        int               pos [3];
        int               w;
        logic             dup;
        m = rand_msg();
        p = encode(m);
        r = m;
        r[0] = r[0] ^ 8'h01;
        r[63] = r[63] ^ 8'hFF;
        decode(r, p);
        checks++;
        if (obs_eu !== 1'b1 || obs_ec !== 1'b0 || obs_mo !== r || obs_ep !== 7'd0) begin
            errors++;
            $display("FAIL double_fixed: ec=%b eu=%b pos=%0d msg=%h want 0/1/0 msg=%h", obs_ec, obs_eu, obs_ep, obs_mo, r);
        end
        for (int n = 0; n < 30; n++) begin
            m = rand_msg();
            p = encode(m);
            r = m;
            w = (n % 3 == 0) ? 2 : 3;
            for (int i = 0; i < w; i++) begin
                do begin
                    pos[i] = $urandom_range(0, 67);
                    dup = 1'b0;
                    for (int j = 0; j < i; j++) if (pos[j] == pos[i]) dup = 1'b1;
                end while (dup);
                if (pos[i] < 64) r[pos[i]] = r[pos[i]] ^ 8'($urandom_range(1, 255));
                else             p[pos[i]-64] = p[pos[i]-64] ^ 8'($urandom_range(1, 255));
            end
            decode(r, p);
            checks++;
            if (obs_eu !== 1'b1 || obs_ec !== 1'b0 || obs_mo !== r) begin
                errors++;
                $display("FAIL multi_%0d_w%0d: ec=%b eu=%b msg=%h want 0/1 msg=%h", n, w, obs_ec, obs_eu, obs_mo, r);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0][7:0] tm [0:2];
        logic [3:0][7:0]  tp [0:2];
        logic [63:0][7:0] want [0:2];
        logic [1:0]       wantf [0:2];
        int               acc [$];
        int               vld [$];
        logic [63:0][7:0] got [$];
        logic [1:0]       gotf [$];
        int               nxt, a, v;
        logic             took;
        for (int b = 0; b < 3; b++) begin
            tm[b] = rand_msg();
            tp[b] = encode(tm[b]);
            want[b] = tm[b];
        end
        wantf[0] = 2'b00;
        tm[1][10] = tm[1][10] ^ 8'h5A;
        wantf[1] = 2'b10;
        tm[2][3] = tm[2][3] ^ 8'h11;
        tp[2][1] = tp[2][1] ^ 8'h22;
        want[2] = tm[2];
        wantf[2] = 2'b01;

        @(negedge clk);
        cw_msg_in = tm[0]; cw_parity_in = tp[0]; cw_valid = 1'b1;
        nxt = 1;
        for (int c = 0; c <= 230; c++) begin
            took = cw_valid && cw_ready;
            if (took) acc.push_back(c);
            @(posedge clk);
            @(negedge clk);
            if (msg_valid) begin
                vld.push_back(c);
                got.push_back(msg_out);
                gotf.push_back({err_corrected, err_uncorrectable});
            end
            if (took) begin
                if (nxt < 3) begin
                    cw_msg_in = tm[nxt]; cw_parity_in = tp[nxt]; nxt++;
                end else begin
                    cw_valid = 1'b0;
                end
            end
        end
        checks++;
        if (acc.size() != 3 || vld.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d strobes=%0d want 3/3", acc.size(), vld.size());
        end
        for (int b = 0; b < 3; b++) begin
            a = (acc.size() > b) ? acc[b] : -1;
            v = (vld.size() > b) ? vld[b] : -1;
            checks++;
            if (a != 71*b || v != 70 + 71*b) begin
                errors++;
                $display("FAIL b2b_timing_%0d: accept=E%0d strobe=E%0d want E%0d/E%0d", b, a, v, 71*b, 70 + 71*b);
            end
            if (got.size() > b) begin
                checks++;
                if (got[b] !== want[b] || gotf[b] !== wantf[b]) begin
                    errors++;
                    $display("FAIL b2b_data_%0d: msg=%h flags=%b want msg=%h flags=%b", b, got[b], gotf[b], want[b], wantf[b]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0][7:0] m, r;
        int               pulses;
        m = rand_msg();
        r = m;
        r[20] = r[20] ^ 8'h3C;
        decode(r, encode(m));               // leaves nonzero outputs behind
        m = rand_msg();
        @(negedge clk);
        cw_msg_in = m; cw_parity_in = encode(m); cw_valid = 1'b1;
        @(posedge clk);                     // E0
        @(negedge clk);
        cw_valid = 1'b0;
        repeat (30) @(posedge clk);         // E30
        #1 rst = 1'b1;
        #1;
        checks++;
        if (cw_ready !== 1'b1 || msg_valid !== 1'b0 || msg_out !== '0 ||
            err_corrected !== 1'b0 || err_uncorrectable !== 1'b0 || err_pos !== 7'd0) begin
            errors++;
            $display("FAIL midrst_clear: rdy=%b vld=%b ec=%b eu=%b pos=%0d msg=%h want 1/0/0/0/0/0",
                     cw_ready, msg_valid, err_corrected, err_uncorrectable, err_pos, msg_out);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (msg_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || cw_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_abort: strobes=%0d rdy=%b want 0/1", pulses, cw_ready);
        end
        m = rand_msg();
        decode(m, encode(m));
        checks++;
        if (obs_lat !== 70 || obs_mo !== m || obs_ec !== 1'b0 || obs_eu !== 1'b0) begin
            errors++;
            $display("FAIL midrst_next: lat=%0d msg=%h ec=%b eu=%b want 70 msg=%h 0/0", obs_lat, obs_mo, obs_ec, obs_eu, m);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        cw_valid = 1'b0;
        cw_msg_in = '0;
        cw_parity_in = '0;
        build_gen();
        test_reset();
        test_zero();
        test_clean_random();
        test_single();
        test_parity();
        test_multi();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
